bit_stream_serializer: RTL
==========================

// Module: bit_stream_serializer
// PURPOSE
//  Upstream feeder for the serial palindrome detector. Accepts parallel words over a
//  valid/ready handshake and emits them MSB-first, one bit per CLK, on OUT. OUT connects
//  to the detector's In. OUT_VALID qualifies each bit. A one-word holding buffer lets
//  consecutive words stream with no idle cycle between them.
// PARAMETERS
//  WIDTH     5   data bits per word (>=2); 5 matches the detector window
//  GAP       0   forced idle cycles after each word (0..15)
//  IDLE_LVL  0   value driven on OUT whenever OUT_VALID=0
// PORTS
//  CLK        in   1      sole clock, rising edge
//  RST_N      in   1      synchronous, active-low reset
//  DIN        in   WIDTH  parallel word, bit WIDTH-1 sent first
//  DIN_VALID  in   1      DIN valid
//  DIN_READY  out  1      holding buffer empty; transfer when DIN_VALID&&DIN_READY at edge
//  OUT        out  1      serial bit stream (registered)
//  OUT_VALID  out  1      OUT carries a word bit this cycle (registered)
//  WORD_DONE  out  1      1-cycle pulse coincident with final bit of a word
//  BUSY       out  1      FSM not IDLE or holding buffer full
// BEHAVIOUR
//  - Reset (RST_N=0 at edge): FSM=IDLE, hold empty, shift/count cleared, OUT=IDLE_LVL,
//    OUT_VALID=0, WORD_DONE=0. DIN_READY = hold_empty && RST_N, so it is 0 while RST_N=0.
//  - Reset mid-word: current and held words are discarded. No WORD_DONE is issued.
//    OUT_VALID=0 from the next cycle.
//  - Holding buffer: loaded on an accepted transfer, emptied when the FSM loads the shifter.
//    Accept and unload in the same edge: the new word enters hold, and the old word moves to
//    the shifter.
//  - FSM states IDLE, SHIFT, GAP:
//    IDLE : hold full -> load shifter, cnt=0, go SHIFT.
//    SHIFT: OUT=shift[WIDTH-1], OUT_VALID=1, shift left each edge, cnt++.
//           On last bit: WORD_DONE=1. Then GAP>0 -> GAP. Else hold full -> reload, stay SHIFT.
//           Else -> IDLE.
//    GAP  : OUT=IDLE_LVL, OUT_VALID=0 for exactly GAP cycles, then same exit as SHIFT end.
//  - Latency: word accepted at edge k with FSM IDLE -> loaded at edge k+1.
//    MSB is on OUT during the cycle after edge k+1. Bits follow on consecutive cycles.
//  - Back-to-back (GAP=0, hold refilled in time): OUT_VALID stays 1 across word boundaries.
//  - cnt width = $clog2(WIDTH+1). Compare against WIDTH-1, or WIDTH with parity; no wrap.
//  - DIN sampled only on accepted edges. DIN changes while DIN_READY=0 are ignored.
// CONFIGURATION
//  SER_PARITY_EN defined: after the WIDTH data bits, one extra bit is sent with OUT_VALID=1.
//    Its value is ^word (even parity). WORD_DONE moves to the parity bit.
//    A word occupies WIDTH+1 cycles.
//  SER_PARITY_EN undefined: WIDTH bits per word, no parity logic present.
// TESTING
//  1 WIDTH=5, GAP=0, DIN=5'b10101 one transfer -> OUT 1,0,1,0,1 with OUT_VALID=1 for
//    5 cycles; WORD_DONE on 5th; then OUT_VALID=0, OUT=0, BUSY=0.
//  2 DIN=5'b11011 then 5'b00100 with DIN_VALID held -> 10 contiguous valid bits
//    1101100100; WORD_DONE on bits 5 and 10.
//  3 GAP=2, same two words -> 2 cycles OUT_VALID=0, OUT=IDLE_LVL between word 1 and word 2.
//  4 Three words offered back-to-back -> DIN_READY=0 while hold full.
//    No word lost or duplicated; order preserved.
//  5 RST_N=0 for 1 cycle after 2 bits of 5'b11100 -> OUT_VALID=0 next cycle, no WORD_DONE,
//    DIN_READY=1 after release.
//  6 SER_PARITY_EN, DIN=5'b10110 -> OUT 1,0,1,1,0,1 (parity 1); WORD_DONE on 6th bit.

Source files
------------

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder: one-word holding buffer, MSB-first shifter, optional idle gap per word.
// Define SER_PARITY_EN to append an even-parity bit after each word's data bits.
module bit_stream_serializer #(
    parameter int WIDTH    = 5,
    parameter int GAP      = 0,
    parameter bit IDLE_LVL = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             OUT,
    output logic             OUT_VALID,
    output logic             WORD_DONE,
    output logic             BUSY
);

    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
    localparam int BITS = WIDTH + 1;
    localparam logic [CNT_W-1:0] PAR_IDX = CNT_W'(WIDTH);
`else
    localparam int BITS = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hold_p0;
    logic               hold_full_p0;
    logic [WIDTH-1:0]   shift_p1, shift_d;
    logic [CNT_W-1:0]   cnt_p1, cnt_d, cnt_inc;
    logic [3:0]         gcnt_p1, gcnt_d;
    logic               out_p1, out_d;
    logic               vld_p1, vld_d;
    logic               done_p1, done_d;
    logic               accept, load, word_end, gap_end;
`ifdef SER_PARITY_EN
    logic               par_p1, par_d;

    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction
`endif

    assign accept   = DIN_VALID && DIN_READY;
    // cnt_p1 is the index of the bit currently on OUT
    assign word_end = (state_q == S_SHIFT) && (cnt_p1 == LAST_IDX);
    assign gap_end  = (state_q == S_GAP) && (gcnt_p1 == GAP_LAST);

    // ---- stage p0: holding buffer ----
    always_ff @(posedge CLK) begin
        if (!RST_N) hold_full_p0 <= 1'b0;
        else        hold_full_p0 <= (hold_full_p0 && !load) || accept;
    end

    always_ff @(posedge CLK) begin
        if (accept) hold_p0 <= DIN;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hold_full_p0) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT, S_GAP: begin
                if (word_end && (GAP > 0)) begin
                    state_d = S_GAP;
                end else if (word_end || gap_end) begin
                    if (hold_full_p0) begin
                        load    = 1'b1;
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_p1;
        cnt_d   = cnt_p1;
        cnt_inc = cnt_p1 + CNT_ONE;
        gcnt_d  = '0;
        out_d   = IDLE_LVL;
        vld_d   = 1'b0;
        done_d  = 1'b0;
`ifdef SER_PARITY_EN
        par_d   = par_p1;
`endif
        if (load) begin
            out_d   = hold_p0[WIDTH-1];
            shift_d = hold_p0 << 1;
            cnt_d   = '0;
            vld_d   = 1'b1;
`ifdef SER_PARITY_EN
            par_d   = even_parity(hold_p0);
`endif
        end else if ((state_q == S_SHIFT) && !word_end) begin
            out_d   = shift_p1[WIDTH-1];
`ifdef SER_PARITY_EN
            if (cnt_inc == PAR_IDX) out_d = par_p1;
`endif
            shift_d = shift_p1 << 1;
            cnt_d   = cnt_inc;
            vld_d   = 1'b1;
            done_d  = (cnt_inc == LAST_IDX);
        end else if ((state_q == S_GAP) && !gap_end) begin
            gcnt_d  = gcnt_p1 + 4'd1;
        end
    end

    // ---- stage p1: shifter and registered serial outputs ----
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            shift_p1 <= '0;
            cnt_p1   <= '0;
            gcnt_p1  <= '0;
            out_p1   <= IDLE_LVL;
            vld_p1   <= 1'b0;
            done_p1  <= 1'b0;
        end else begin
            shift_p1 <= shift_d;
            cnt_p1   <= cnt_d;
            gcnt_p1  <= gcnt_d;
            out_p1   <= out_d;
            vld_p1   <= vld_d;
            done_p1  <= done_d;
        end
    end

`ifdef SER_PARITY_EN
    always_ff @(posedge CLK) begin
        par_p1 <= par_d;
    end
`endif

    assign DIN_READY = !hold_full_p0 && RST_N;
    assign OUT       = out_p1;
    assign OUT_VALID = vld_p1;
    assign WORD_DONE = done_p1;
    assign BUSY      = (state_q != S_IDLE) || hold_full_p0;

endmodule
